datapath_ctrl: RTL and testbench
================================

DATAPATH_CTRL -- requirements
Module: datapath_ctrl

Interface
REQ-001 The block SHALL have the following ports, one per line (name, direction, width, meaning):
- clock  input  1  single clock; all state updates on posedge.
- reset_n  input  1  reset, asynchronous, active-low.
- instr_valid  input  1  instruction offered.
- instr_ready  output  1  block can accept an instruction.
- opcode  input  2  00 LOAD, 01 ADD, 10 CLEAR, 11 READ.
- operand  input  4  immediate operand.
- acc_in  input  4  accumulator value fed back from the datapath OutBus.
- ABus  output  4  operand bus to the datapath.
- SelB  output  1  datapath mux select; 0 = ABus, 1 = ABus+AC.
- LoadAC  output  1  datapath accumulator load strobe.
- AddAlu  output  1  add-operation indicator to the datapath.
- result  output  4  accumulator value reported for the completed instruction.
- carry  output  1  sticky add overflow flag.
- result_valid  output  1  result/carry valid.
- result_ready  input  1  consumer accepts result.

Function
REQ-002 The FSM SHALL have states IDLE, EXEC, WAIT and RESP.
REQ-003 instr_ready SHALL be 1 only in IDLE.
REQ-004 Acceptance SHALL occur on a clock edge where instr_valid=1 and instr_ready=1; opcode and operand SHALL then be latched internally.
REQ-005 On acceptance the FSM SHALL go IDLE->EXEC for LOAD/ADD/CLEAR, and IDLE->WAIT for READ.
REQ-006 In EXEC the block SHALL drive LoadAC=1 for exactly one cycle, with:
- LOAD: ABus=operand, SelB=0.
- CLEAR: ABus=0, SelB=0.
- ADD: ABus=operand, SelB=1, AddAlu=1.
EXEC SHALL always go to WAIT on the next cycle.
REQ-007 Outside EXEC, LoadAC, SelB and AddAlu SHALL be 0 and ABus SHALL hold the latched operand (0 after CLEAR).
REQ-008 In EXEC for ADD, carry SHALL be set if acc_in + operand > 15 (5-bit sum), computed from acc_in sampled in that cycle; carry is sticky and is not cleared by a later ADD without overflow.
REQ-009 LOAD and CLEAR SHALL clear carry in EXEC; READ SHALL leave carry unchanged.
REQ-010 Accumulator arithmetic in the datapath SHALL wrap modulo 16; the block SHALL NOT saturate.
REQ-011 In WAIT the block SHALL capture acc_in into result and go to RESP on the next edge.
REQ-012 In RESP, result_valid SHALL be 1, and result and carry SHALL be held stable until result_ready=1.
REQ-013 The block SHALL go RESP->IDLE on the edge where result_ready=1.
REQ-014 An instruction SHALL NOT be accepted in the same cycle a response is retired; the earliest next acceptance is the following cycle.
REQ-015 Latency from the acceptance edge to result_valid=1 SHALL be:
- 3 cycles for LOAD/ADD/CLEAR.
- 2 cycles for READ.
REQ-016 instr_valid held high while the FSM is not in IDLE SHALL be ignored; no instruction is queued.
REQ-017 The block SHALL NOT rely on a datapath reset; the datapath accumulator is unknown until the first LOAD or CLEAR completes.

Reset
REQ-018 While reset_n=0, regardless of current state, the block SHALL:
- set the FSM to IDLE.
- drive ABus=0, SelB=0, LoadAC=0, AddAlu=0, result=0, carry=0, result_valid=0.
- drive instr_ready=1 after release.
REQ-019 Reset asserted during EXEC SHALL drop LoadAC immediately (asynchronously), so no datapath load occurs on the next edge.
REQ-020 Reset SHALL NOT be applied to the datapath accumulator by this block.

Verification
REQ-021 CLEAR then READ -> result=0, carry=0; result_valid at acceptance+3 and acceptance+2 respectively.
REQ-022 LOAD 9, then ADD 4 -> result=13, carry=0; then ADD 5 -> result=2 (wrap), carry=1; then ADD 1 -> result=3, carry stays 1.
REQ-023 LOAD 7 after carry=1 -> carry=0, result=7.
REQ-024 Backpressure: result_ready=0 for 5 cycles in RESP -> result_valid, result and carry stable throughout; instr_ready=0 throughout; instr_valid pulses in that window are ignored.
REQ-025 reset_n pulsed low during EXEC of LOAD 5 -> LoadAC falls without waiting for a clock edge; outputs take their reset values; the accumulator keeps its prior value (confirmed by CLEAR/LOAD-free READ after reset).
REQ-026 Back-to-back instructions with instr_valid held high -> one acceptance per RESP->IDLE cycle; the FSM never skips IDLE.

Source files
------------

// File: rtl/datapath_ctrl_if.sv
// Instruction/response handshake and datapath control bus between datapath_ctrl
// and its environment (instruction source, accumulator datapath, result consumer).
interface datapath_ctrl_if #(
    parameter int DATA_W = 4
);
    logic              instr_valid;
    logic              instr_ready;
    logic [1:0]        opcode;
    logic [DATA_W-1:0] operand;
    logic [DATA_W-1:0] acc_in;
    logic [DATA_W-1:0] ABus;
    logic              SelB;
    logic              LoadAC;
    logic              AddAlu;
    logic [DATA_W-1:0] result;
    logic              carry;
    logic              result_valid;
    logic              result_ready;

    modport slave (
        input  instr_valid, opcode, operand, acc_in, result_ready,
        output instr_ready, ABus, SelB, LoadAC, AddAlu, result, carry, result_valid
    );

    modport master (
        output instr_valid, opcode, operand, acc_in, result_ready,
        input  instr_ready, ABus, SelB, LoadAC, AddAlu, result, carry, result_valid
    );
endinterface

// File: rtl/datapath_ctrl.sv
// Single-issue controller for an external accumulator datapath: accepts one
// instruction, drives the datapath load for it, then reports the accumulator.
module datapath_ctrl #(
    parameter int DATA_W = 4
) (
    input  logic           clock,
    input  logic           reset_n,
    datapath_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, WAIT, RESP} state_t;
    typedef enum logic [1:0] {OP_LOAD = 2'b00, OP_ADD = 2'b01, OP_CLEAR = 2'b10, OP_READ = 2'b11} op_t;

    state_t            state;
    state_t            state_nxt;
    op_t               opcode_q;
    logic [DATA_W-1:0] operand_q;
    logic [DATA_W-1:0] result_q;
    logic              carry_q;
    logic              accept;

    function automatic logic add_carry(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        logic [DATA_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[DATA_W];
    endfunction

    assign accept = (state == IDLE) && bus.instr_valid;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath strobes are decoded from state alone so an async reset drops LoadAC at once
    always_comb begin
        state_nxt       = state;
        bus.instr_ready = 1'b0;
        bus.LoadAC      = 1'b0;
        bus.SelB        = 1'b0;
        bus.AddAlu      = 1'b0;
        case (state)
            IDLE: begin
                bus.instr_ready = 1'b1;
                if (bus.instr_valid) begin
                    state_nxt = (op_t'(bus.opcode) == OP_READ) ? WAIT : EXEC;
                end
            end
            EXEC: begin
                bus.LoadAC = 1'b1;
                bus.SelB   = (opcode_q == OP_ADD);
                bus.AddAlu = (opcode_q == OP_ADD);
                state_nxt  = WAIT;
            end
            WAIT: begin
                state_nxt = RESP;
            end
            RESP: begin
                if (bus.result_ready) begin
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            opcode_q  <= OP_LOAD;
            operand_q <= '0;
            result_q  <= '0;
            carry_q   <= 1'b0;
        end else begin
            if (accept) begin
                opcode_q  <= op_t'(bus.opcode);
                // CLEAR latches zero so ABus carries the cleared value into and after EXEC
                operand_q <= (op_t'(bus.opcode) == OP_CLEAR) ? '0 : bus.operand;
            end
            if (state == EXEC) begin
                if (opcode_q == OP_ADD) begin
                    if (add_carry(bus.acc_in, operand_q)) begin
                        carry_q <= 1'b1;
                    end
                end else begin
                    carry_q <= 1'b0;
                end
            end
            if (state == WAIT) begin
                result_q <= bus.acc_in;
            end
        end
    end

    assign bus.ABus         = operand_q;
    assign bus.result       = result_q;
    assign bus.carry        = carry_q;
    assign bus.result_valid = (state == RESP);

endmodule

// File: tb/tb_datapath_ctrl.sv
// Bench for datapath_ctrl with a behavioural accumulator datapath, directed
// vector table, reset/back-to-back sequences and randomized instructions.
module tb_datapath_ctrl;
    localparam logic [1:0] LOAD  = 2'b00;
    localparam logic [1:0] ADD   = 2'b01;
    localparam logic [1:0] CLEAR = 2'b10;
    localparam logic [1:0] READ  = 2'b11;

    logic clock;
    logic reset_n;
    logic [3:0] dp_acc;

    datapath_ctrl_if bus ();

    datapath_ctrl dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Accumulator datapath: load ABus or ABus+AC, wrapping modulo 16, never reset
    always @(posedge clock) begin
        if (bus.LoadAC) begin
            dp_acc <= bus.SelB ? (bus.ABus + dp_acc) : bus.ABus;
        end
    end
    assign bus.acc_in = dp_acc;

    int checks = 0;
    int errors = 0;

    // Reference model of the architectural state
    int m_acc   = 0;
    int m_carry = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_step(input logic [1:0] op, input int opd);
        case (op)
            LOAD:  begin m_acc = opd; m_carry = 0; end
            CLEAR: begin m_acc = 0;   m_carry = 0; end
            ADD: begin
                if (m_acc + opd > 15) m_carry = 1;
                m_acc = (m_acc + opd) % 16;
            end
            default: ;
        endcase
    endtask

    task automatic do_instr(input logic [1:0] op, input logic [3:0] opd, input int hold,
                            output logic [3:0] res, output logic cy);
        int n;
        int lat;
        logic [3:0] r0;
        logic c0;
        @(negedge clock);
        bus.instr_valid = 1'b1;
        bus.opcode      = op;
        bus.operand     = opd;
        n = 0;
        while (!bus.instr_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("accept_ready", int'(bus.instr_ready), 1);
        @(negedge clock);
        bus.instr_valid = 1'b0;
        model_step(op, int'(opd));
        lat = 1;
        if (op != READ) begin
            chk("exec_loadac", int'(bus.LoadAC), 1);
            chk("exec_selb", int'(bus.SelB), (op == ADD) ? 1 : 0);
            chk("exec_addalu", int'(bus.AddAlu), (op == ADD) ? 1 : 0);
            chk("exec_abus", int'(bus.ABus), (op == CLEAR) ? 0 : int'(opd));
        end else begin
            chk("read_no_load", int'(bus.LoadAC), 0);
        end
        while (!bus.result_valid && lat < 10) begin
            @(negedge clock);
            lat++;
            if (lat == 2 && op != READ) chk("loadac_pulse", int'(bus.LoadAC), 0);
        end
        chk("latency", lat, (op == READ) ? 2 : 3);
        r0 = bus.result;
        c0 = bus.carry;
        for (int i = 0; i < hold; i++) begin
            chk("bp_valid", int'(bus.result_valid), 1);
            chk("bp_result", int'(bus.result), int'(r0));
            chk("bp_carry", int'(bus.carry), int'(c0));
            chk("bp_ready_low", int'(bus.instr_ready), 0);
            bus.instr_valid = 1'($urandom_range(0, 1));
            bus.opcode      = 2'($urandom_range(0, 3));
            bus.operand     = 4'($urandom_range(0, 15));
            @(negedge clock);
        end
        bus.instr_valid  = 1'b0;
        chk("rv_at_retire", int'(bus.result_valid), 1);
        res = bus.result;
        cy  = bus.carry;
        bus.result_ready = 1'b1;
        @(negedge clock);
        bus.result_ready = 1'b0;
        chk("idle_after_resp", int'(bus.instr_ready), 1);
        chk("idle_valid_low", int'(bus.result_valid), 0);
        chk("model_result", int'(res), m_acc);
        chk("model_carry", int'(cy), m_carry);
    endtask

    typedef struct {
        logic [1:0] op;
        logic [3:0] opd;
        int         hold;
        logic [3:0] exp_res;
        logic       exp_cy;
        logic [3:0] exp_abus;
    } vec_t;

    vec_t tbl[8];

    initial begin
        logic [3:0] res;
        logic cy;
        int accepts;
        logic prev_rv;
        logic [1:0] rop;
        logic [3:0] ropd;

        tbl[0] = '{CLEAR, 4'd6,  0, 4'd0,  1'b0, 4'd0};
        tbl[1] = '{READ,  4'd0,  1, 4'd0,  1'b0, 4'd0};
        tbl[2] = '{LOAD,  4'd9,  0, 4'd9,  1'b0, 4'd9};
        tbl[3] = '{ADD,   4'd4,  2, 4'd13, 1'b0, 4'd4};
        tbl[4] = '{ADD,   4'd5,  5, 4'd2,  1'b1, 4'd5};
        tbl[5] = '{ADD,   4'd1,  0, 4'd3,  1'b1, 4'd1};
        tbl[6] = '{READ,  4'd10, 0, 4'd3,  1'b1, 4'd10};
        tbl[7] = '{LOAD,  4'd7,  1, 4'd7,  1'b0, 4'd7};

        reset_n          = 1'b0;
        bus.instr_valid  = 1'b0;
        bus.opcode       = LOAD;
        bus.operand      = 4'd0;
        bus.result_ready = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_abus", int'(bus.ABus), 0);
        chk("rst_loadac", int'(bus.LoadAC), 0);
        chk("rst_selb", int'(bus.SelB), 0);
        chk("rst_addalu", int'(bus.AddAlu), 0);
        chk("rst_result", int'(bus.result), 0);
        chk("rst_carry", int'(bus.carry), 0);
        chk("rst_rvalid", int'(bus.result_valid), 0);
        reset_n = 1'b1;
        @(negedge clock);
        chk("rst_instr_ready", int'(bus.instr_ready), 1);

        for (int i = 0; i < 8; i++) begin
            do_instr(tbl[i].op, tbl[i].opd, tbl[i].hold, res, cy);
            chk($sformatf("vec%0d_result", i), int'(res), int'(tbl[i].exp_res));
            chk($sformatf("vec%0d_carry", i), int'(cy), int'(tbl[i].exp_cy));
            chk($sformatf("vec%0d_abus_idle", i), int'(bus.ABus), int'(tbl[i].exp_abus));
        end

        // Reset pulse while a LOAD 5 is in EXEC; accumulator must keep 7
        @(negedge clock);
        bus.instr_valid = 1'b1;
        bus.opcode      = LOAD;
        bus.operand     = 4'd5;
        @(negedge clock);
        bus.instr_valid = 1'b0;
        chk("rexec_loadac_pre", int'(bus.LoadAC), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("rexec_loadac_async", int'(bus.LoadAC), 0);
        chk("rexec_abus", int'(bus.ABus), 0);
        chk("rexec_selb", int'(bus.SelB), 0);
        chk("rexec_result", int'(bus.result), 0);
        chk("rexec_carry", int'(bus.carry), 0);
        chk("rexec_rvalid", int'(bus.result_valid), 0);
        @(negedge clock);
        reset_n = 1'b1;
        m_carry = 0;
        @(negedge clock);
        chk("rexec_ready", int'(bus.instr_ready), 1);
        do_instr(READ, 4'd0, 0, res, cy);
        chk("rexec_acc_kept", int'(res), 7);
        chk("rexec_carry_read", int'(cy), 0);

        // Back-to-back ADD 1 with instr_valid and result_ready held high
        bus.result_ready = 1'b1;
        bus.opcode       = ADD;
        bus.operand      = 4'd1;
        bus.instr_valid  = 1'b1;
        accepts = 0;
        prev_rv = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (prev_rv) chk("b2b_idle_after_resp", int'(bus.instr_ready), 1);
            if (bus.result_valid) chk("b2b_result", int'(bus.result), m_acc);
            if (bus.instr_valid && bus.instr_ready) begin
                accepts++;
                model_step(ADD, 1);
            end
            prev_rv = bus.result_valid;
            @(negedge clock);
        end
        bus.instr_valid  = 1'b0;
        bus.result_ready = 1'b0;
        chk("b2b_accepts", accepts, 10);
        chk("b2b_idle_end", int'(bus.instr_ready), 1);

        // Randomized instruction stream against the model
        for (int i = 0; i < 40; i++) begin
            rop  = 2'($urandom_range(0, 3));
            ropd = 4'($urandom_range(0, 15));
            do_instr(rop, ropd, $urandom_range(0, 3), res, cy);
            chk("rand_abus_idle", int'(bus.ABus), (rop == CLEAR) ? 0 : int'(ropd));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
